mux_serializer: RTL and testbench

Parallel-to-serial front end built around the team's 8:1 mux (`Mux_81`). It accepts an 8-bit word over a valid/ready handshake and holds it in a register feeding the mux. It steps the mux `select` through all eight positions and presents each selected bit as a valid/ready serial stream, flagging the final bit of each word. It sits directly around the mux: it drives the mux inputs and select, and it consumes the mux output.

---
 rtl/mux_ser_pkg.sv | 28 ++
 rtl/mux_serializer_mux81.sv | 11 +
 rtl/mux_serializer.sv | 96 +++++++++
 tb/tb_mux_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ser_pkg.sv
// Shared types and constants for the mux-based serializer.
// Index start/end positions depend on bit order.
package mux_ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int WORD_W = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] LSB_POS = 3'd0;
  localparam logic [SEL_W-1:0] MSB_POS = 3'd7;

  function automatic logic [SEL_W-1:0] start_idx(
    input bit msb_first
  );
    return msb_first ? MSB_POS : LSB_POS;
  endfunction

  function automatic logic [SEL_W-1:0] end_idx(
    input bit msb_first
  );
    return msb_first ? LSB_POS : MSB_POS;
  endfunction

endpackage

// File: rtl/mux_serializer_mux81.sv
// Team 8:1 mux: picks one bit of an 8-bit input.
// Purely combinational.
module Mux_81 (
  input  logic [7:0] in,
  input  logic [2:0] select,
  output logic       out
);

  assign out = in[select];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-to-serial front end around Mux_81.
// Word register feeds the mux; select walks the bit order.
module mux_serializer
  import mux_ser_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_data,
  output logic       ser_last,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam logic [SEL_W-1:0] START = start_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] FIN   = end_idx(MSB_FIRST);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [7:0]          frame_q, frame_d;

  logic mux_out;
  logic shifting;
  logic at_end;
  logic bit_fire;
  logic done;
  logic load_fire;

  Mux_81 u_mux (
    .in     (word_q),
    .select (idx_q),
    .out    (mux_out)
  );

  always_comb begin
    shifting  = (state_q == SHIFT);
    at_end    = shifting && (idx_q == FIN);
    bit_fire  = shifting && ser_ready;
    done      = bit_fire && at_end;
    // rst_n gate keeps load_ready low while held in reset
    load_ready = rst_n && (!shifting || done);
    load_fire  = load_valid && load_ready;

    ser_valid   = shifting;
    ser_last    = at_end;
    ser_data    = shifting & mux_out;
    busy        = shifting;
    frame_count = frame_q;

    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    frame_d = frame_q;

    unique case (1'b1)
      load_fire: begin
        state_d = SHIFT;
        word_d  = load_data;
        idx_d   = START;
      end
      done && !load_valid: begin
        state_d = IDLE;
      end
      bit_fire && !at_end: begin
        idx_d = MSB_FIRST ? idx_q - 3'd1 : idx_q + 3'd1;
      end
      default: ;
    endcase

    if (done) begin
      frame_d = frame_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench for mux_serializer, LSB- and MSB-first.
// Expected bits are queued on load and popped per handshake.
module tb_mux_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       lv_a, lr_a, sv_a, sr_a, sd_a, sl_a, busy_a;
  logic [7:0] ld_a, fc_a;
  logic       lv_b, lr_b, sv_b, sr_b, sd_b, sl_b, busy_b;
  logic [7:0] ld_b, fc_b;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [7:0] fc_exp_a = 8'd0;
  logic [7:0] fc_exp_b = 8'd0;

  always #5 clk = ~clk;

  mux_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (lv_a),
    .load_ready  (lr_a),
    .load_data   (ld_a),
    .ser_valid   (sv_a),
    .ser_ready   (sr_a),
    .ser_data    (sd_a),
    .ser_last    (sl_a),
    .busy        (busy_a),
    .frame_count (fc_a)
  );

  mux_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (lv_b),
    .load_ready  (lr_b),
    .load_data   (ld_b),
    .ser_valid   (sv_b),
    .ser_ready   (sr_b),
    .ser_data    (sd_b),
    .ser_last    (sl_b),
    .busy        (busy_b),
    .frame_count (fc_b)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      fc_exp_a = 8'd0;
      fc_exp_b = 8'd0;
      chk("rst_lr_a", 32'(lr_a), 0);
      chk("rst_out_a", 32'({sv_a, sd_a, sl_a, busy_a}), 0);
      chk("rst_lr_b", 32'(lr_b), 0);
      chk("rst_out_b", 32'({sv_b, sd_b, sl_b, busy_b}), 0);
      chk("rst_fc_a", 32'(fc_a), 0);
    end else begin
      if (!sv_a) chk("gate_a", 32'({sd_a, sl_a}), 0);
      if (!sv_b) chk("gate_b", 32'({sd_b, sl_b}), 0);
      chk("fc_a", 32'(fc_a), 32'(fc_exp_a));
      chk("fc_b", 32'(fc_b), 32'(fc_exp_b));
      if (sv_a && sr_a) begin
        if (q_a.size() == 0) begin
          chk("a_extra_bit", 1, 0);
        end else begin
          e = q_a.pop_front();
          chk("a_data", 32'(sd_a), 32'(e[1]));
          chk("a_last", 32'(sl_a), 32'(e[0]));
        end
        if (sl_a) fc_exp_a = fc_exp_a + 8'd1;
      end
      if (sv_b && sr_b) begin
        if (q_b.size() == 0) begin
          chk("b_extra_bit", 1, 0);
        end else begin
          e = q_b.pop_front();
          chk("b_data", 32'(sd_b), 32'(e[1]));
          chk("b_last", 32'(sl_b), 32'(e[0]));
        end
        if (sl_b) fc_exp_b = fc_exp_b + 8'd1;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic load(
    input  bit         b,
    input  logic [7:0] w,
    output bit         last_seen
  );
    bit ok;
    int idx;
    ok = 1'b0;
    last_seen = 1'b0;
    if (b) begin
      lv_b = 1'b1;
      ld_b = w;
    end else begin
      lv_a = 1'b1;
      ld_a = w;
    end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (b ? lr_b : lr_a) ok = 1'b1;
    end
    if (ok) begin
      last_seen = b ? sl_b : sl_a;
      for (int k = 0; k < 8; k++) begin
        idx = b ? 7 - k : k;
        if (b) q_b.push_back({w[idx], k == 7});
        else   q_a.push_back({w[idx], k == 7});
      end
    end else begin
      chk(b ? "b_load_timeout" : "a_load_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    if (b) lv_b = 1'b0;
    else   lv_a = 1'b0;
  endtask

  task automatic wait_idle(input bit b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (b) ok = !busy_b && q_b.size() == 0;
      else   ok = !busy_a && q_a.size() == 0;
    end
    if (!ok) chk(b ? "b_idle_timeout" : "a_idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ls;
    lv_a = 1'b0; ld_a = 8'h00; sr_a = 1'b1;
    lv_b = 1'b0; ld_b = 8'h00; sr_b = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lr", 32'(lr_a), 0);
    chk("reset_valid", 32'(sv_a), 0);
    chk("reset_fc", 32'(fc_a), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_lr", 32'(lr_a), 1);
    chk("idle_busy", 32'(busy_a), 0);

    load(1'b0, 8'b10101010, ls);
    chk("t1_accept_from_idle", 32'(ls), 0);
    chk("t1_busy", 32'(busy_a), 1);
    wait_idle(1'b0);
    chk("t1_fc", 32'(fc_a), 1);
    chk("t1_back_idle", 32'(busy_a), 0);

    load(1'b1, 8'b11110000, ls);
    wait_idle(1'b1);
    chk("msb_fc", 32'(fc_b), 1);

    load(1'b0, 8'b00001111, ls);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sr_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(sd_a), 1);
      chk("bp_hold_valid", 32'(sv_a), 1);
    end
    @(posedge clk);
    #1;
    sr_a = 1'b1;
    wait_idle(1'b0);
    chk("bp_fc", 32'(fc_a), 2);

    load(1'b0, 8'b01010101, ls);
    load(1'b0, 8'b11001100, ls);
    chk("b2b_accept_on_last", 32'(ls), 1);
    @(negedge clk);
    chk("b2b_no_bubble", 32'(sv_a), 1);
    wait_idle(1'b0);
    chk("b2b_fc", 32'(fc_a), 4);

    load(1'b0, 8'b11111111, ls);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(sv_a), 0);
    chk("abort_last", 32'(sl_a), 0);
    chk("abort_fc", 32'(fc_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load(1'b0, 8'b00000001, ls);
    wait_idle(1'b0);
    chk("restart_fc", 32'(fc_a), 1);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      load(1'b0, 8'($urandom_range(255)), ls);
    end
    wait_idle(1'b0);
    chk("wrap_fc", 32'(fc_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
